// File: rtl/tier_tsv_ser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tier_tsv_ser
// Brief  : Serialises a tier-L3 parallel word LSB-first onto one TSV lane,
//          followed by an even-parity bit, a frame strobe and a frame counter.
// Rev    : 1.0
// ============================================================================
module tier_tsv_ser #(
  parameter int DW      = 8,
  parameter int GAP_CYC = 1
) (
  input  logic          clk1_IN,
  input  logic          rst_IN,
  input  logic [DW-1:0] in_dat_IN,
  input  logic          in_vld_IN,
  output logic          in_rdy_OUT,
  output logic          tsv_dat_OUT,
  output logic          tsv_frm_OUT,
  output logic          busy_OUT,
  output logic [7:0]    frm_cnt_OUT
);

  localparam int            IW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DW - 1);
  localparam logic [3:0]    LAST_GAP = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] shift;
  logic [IW-1:0] bit_idx;
  logic [3:0]    gap_cnt;
  logic          parity;

  always_ff @(posedge clk1_IN) begin
    if (rst_IN) begin
      state       <= IDLE;
      shift       <= '0;
      bit_idx     <= '0;
      gap_cnt     <= '0;
      parity      <= 1'b0;
      in_rdy_OUT  <= 1'b0;
      tsv_dat_OUT <= 1'b0;
      tsv_frm_OUT <= 1'b0;
      busy_OUT    <= 1'b0;
      frm_cnt_OUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld_IN && in_rdy_OUT) begin
            state       <= SEND;
            shift       <= in_dat_IN;
            bit_idx     <= '0;
            parity      <= ^in_dat_IN;
            in_rdy_OUT  <= 1'b0;
            tsv_dat_OUT <= in_dat_IN[0];
            tsv_frm_OUT <= 1'b1;
            busy_OUT    <= 1'b1;
          end else begin
            in_rdy_OUT  <= 1'b1;
          end
        end
        SEND: begin
          tsv_frm_OUT <= 1'b0;
          if (bit_idx == LAST_BIT) begin
            state       <= PAR;
            tsv_dat_OUT <= parity;
          end else begin
            // Rotate so the next payload bit always sits at index 1.
            bit_idx     <= bit_idx + 1'b1;
            shift       <= {shift[0], shift[DW-1:1]};
            tsv_dat_OUT <= shift[1];
          end
        end
        PAR: begin
          tsv_dat_OUT <= 1'b0;
          if (frm_cnt_OUT != 8'hFF) begin
            frm_cnt_OUT <= frm_cnt_OUT + 8'd1;
          end
          if (GAP_CYC > 0) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else begin
            state      <= IDLE;
            busy_OUT   <= 1'b0;
            in_rdy_OUT <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == LAST_GAP) begin
            state      <= IDLE;
            busy_OUT   <= 1'b0;
            in_rdy_OUT <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tier_tsv_ser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_tier_tsv_ser
// Brief  : Bench driving a GAP_CYC=1 and a GAP_CYC=0 serialiser side by side
//          against a frame-position model plus literal frame expectations.
// Rev    : 1.0
// ============================================================================
module tb_tier_tsv_ser;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [DW-1:0] din = '0;

  logic       rdy_a, dat_a, frm_a, busy_a;
  logic       rdy_b, dat_b, frm_b, busy_b;
  logic [7:0] cnt_a, cnt_b;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tier_tsv_ser #(.DW(DW), .GAP_CYC(1)) dut_a (
    .clk1_IN(clk), .rst_IN(rst), .in_dat_IN(din), .in_vld_IN(vld),
    .in_rdy_OUT(rdy_a), .tsv_dat_OUT(dat_a), .tsv_frm_OUT(frm_a),
    .busy_OUT(busy_a), .frm_cnt_OUT(cnt_a)
  );

  tier_tsv_ser #(.DW(DW), .GAP_CYC(0)) dut_b (
    .clk1_IN(clk), .rst_IN(rst), .in_dat_IN(din), .in_vld_IN(vld),
    .in_rdy_OUT(rdy_b), .tsv_dat_OUT(dat_b), .tsv_frm_OUT(frm_b),
    .busy_OUT(busy_b), .frm_cnt_OUT(cnt_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: pos = -2 just out of reset, -1 idle and ready, otherwise the
  // cycle index inside the frame (payload 0..DW-1, parity DW, then gap).
  int            pos  [2] = '{-2, -2};
  int            mcnt [2] = '{0, 0};
  logic [DW-1:0] word [2] = '{'0, '0};

  function automatic int gap_of(input int g);
    return (g == 0) ? 1 : 0;
  endfunction

  function automatic int next_pos(input int g);
    if (rst) return -2;
    if (pos[g] == -1 && vld) return 0;
    if (pos[g] < 0) return -1;
    if (pos[g] + 1 == DW + 1 + gap_of(g)) return -1;
    return pos[g] + 1;
  endfunction

  function automatic int next_cnt(input int g);
    if (rst) return 0;
    if (pos[g] == DW && mcnt[g] < 255) return mcnt[g] + 1;
    return mcnt[g];
  endfunction

  function automatic int exp_dat(input int g);
    if (pos[g] >= 0 && pos[g] < DW) return int'(word[g][pos[g]]);
    if (pos[g] == DW) return int'(^word[g]);
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pos[g]  <= next_pos(g);
      mcnt[g] <= next_cnt(g);
      if (!rst && pos[g] == -1 && vld) word[g] <= din;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdy_a",  int'(rdy_a),  int'(pos[0] == -1));
      chk("busy_a", int'(busy_a), int'(pos[0] >= 0));
      chk("frm_a",  int'(frm_a),  int'(pos[0] == 0));
      chk("dat_a",  int'(dat_a),  exp_dat(0));
      chk("cnt_a",  int'(cnt_a),  mcnt[0]);
      chk("rdy_b",  int'(rdy_b),  int'(pos[1] == -1));
      chk("busy_b", int'(busy_b), int'(pos[1] >= 0));
      chk("frm_b",  int'(frm_b),  int'(pos[1] == 0));
      chk("dat_b",  int'(dat_b),  exp_dat(1));
      chk("cnt_b",  int'(cnt_b),  mcnt[1]);
    end
  end

  // One frame on dut_a with payload scrambled after capture; lane bits,
  // strobe pattern and ready-return latency checked against literals.
  task automatic send_check(input logic [DW-1:0] w, input logic [DW:0] exp_bits,
                            input string nm);
    logic [DW:0] bits;
    logic [DW:0] frms;
    int          rdy_at;
    bits   = '0;
    frms   = '0;
    rdy_at = 0;
    vld    = 1'b1;
    din    = w;
    for (int k = 1; k <= 30 && rdy_at == 0; k++) begin
      @(negedge clk);
      vld = 1'b0;
      if (k <= DW + 1) begin
        bits[k-1] = dat_a;
        frms[k-1] = frm_a;
      end
      if (rdy_a) rdy_at = k;
      din = DW'($urandom);
    end
    chk({nm, "_bits"}, int'(bits), int'(exp_bits));
    chk({nm, "_frm"},  int'(frms), 1);
    chk({nm, "_rdy_latency"}, rdy_at, 11);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(rdy_a && rdy_b) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, int'(rdy_a && rdy_b), 1);
  endtask

  initial begin
    logic [19:0] lane, strb, bsy;

    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_rdy",  int'(rdy_a),  0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_dat",  int'(dat_a),  0);
    chk("reset_cnt",  int'(cnt_a),  0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", int'(rdy_a), 1);

    send_check(8'hA5, 9'b0_1010_0101, "a5");
    chk("a5_cnt", int'(cnt_a), 1);
    send_check(8'h07, 9'b1_0000_0111, "x07");
    chk("x07_cnt", int'(cnt_a), 2);

    // Back-to-back 0x01 then 0xFF with valid held high, observed on dut_b.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vld = 1'b1;
    din = 8'h01;
    lane = '0;
    strb = '0;
    bsy  = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lane[k] = dat_b;
      strb[k] = frm_b;
      bsy[k]  = busy_b;
      din = 8'hFF;
      if (k == 11) vld = 1'b0;
    end
    chk("b2b_lane", int'(lane), 20'h3FD01);
    chk("b2b_frm",  int'(strb), 20'h00401);
    chk("b2b_busy", int'(bsy),  20'h7FDFF);
    wait_idle("b2b");
    chk("b2b_cnt_b", int'(cnt_b), 2);
    chk("b2b_cnt_a", int'(cnt_a), 2);

    // Reset during payload bit 4 of 0xFF.
    vld = 1'b1;
    din = 8'hFF;
    @(negedge clk);
    vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_bit4", int'(dat_a), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_lane", int'(dat_a),  0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_rdy",  int'(rdy_a),  0);
    chk("abort_cnt",  int'(cnt_a),  0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rdy_release", int'(rdy_a), 1);
    repeat (12) @(negedge clk);
    chk("abort_cnt_hold", int'(cnt_a), 0);

    // Reset coinciding with a handshake drops the word.
    vld = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vs_hs_busy", int'(busy_a), 0);

    // Continuous traffic with scrambled data until both counters saturate.
    vld = 1'b1;
    for (int k = 0; k < 3400; k++) begin
      @(negedge clk);
      din = DW'($urandom);
    end
    vld = 1'b0;
    wait_idle("sat");
    chk("sat_cnt_a", int'(cnt_a), 255);
    chk("sat_cnt_b", int'(cnt_b), 255);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/tier_tsv_ser.md
TIER_TSV_SER -- requirements
Module: tier_tsv_ser

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DW, default 8, giving the payload width in bits, one per tier output net.
REQ-002 The block SHALL have parameter GAP_CYC, default 1, giving the number of idle cycles forced between frames (0 to 15).

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk1_IN, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_IN, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_dat_IN, input, DW bits: parallel word of tier-L3 output nets; bit 0 = n255, ascending in tier output order.
REQ-006 The block SHALL have port in_vld_IN, input, 1 bit: in_dat_IN valid.
REQ-007 The block SHALL have port in_rdy_OUT, output, 1 bit: block can accept a word.
REQ-008 The block SHALL have port tsv_dat_OUT, output, 1 bit: serial lane driven onto the TSV cell.
REQ-009 The block SHALL have port tsv_frm_OUT, output, 1 bit: frame strobe on a second TSV, high on the bit-0 cycle only.
REQ-010 The block SHALL have port busy_OUT, output, 1 bit: a frame or gap is in progress.
REQ-011 The block SHALL have port frm_cnt_OUT, output, 8 bits: count of completed frames, saturating.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 The FSM SHALL have exactly the states IDLE, SEND, PAR and GAP.
REQ-014 in_rdy_OUT SHALL be 1 only while in IDLE.
REQ-015 A handshake (in_vld_IN=1 and in_rdy_OUT=1 at edge N) SHALL capture in_dat_IN into the shift register, compute even parity, go to SEND with bit index 0, and drop in_rdy_OUT at N+1.
REQ-016 In SEND, tsv_dat_OUT SHALL present the payload LSB first: bit 0 visible from edge N+1, bit k from edge N+1+k.
REQ-017 tsv_frm_OUT SHALL be 1 only during the bit-0 cycle.
REQ-018 After bit DW-1 the FSM SHALL enter PAR for one cycle, with tsv_dat_OUT = XOR of all payload bits (even parity).
REQ-019 On leaving PAR, frm_cnt_OUT SHALL increment by 1, holding at 255 once reached (no wrap).
REQ-020 From PAR, the FSM SHALL go to GAP for GAP_CYC cycles when GAP_CYC>0, otherwise directly to IDLE.
REQ-021 With GAP_CYC=0, in_rdy_OUT SHALL be 1 in the cycle right after PAR, and back-to-back frames SHALL be separated by exactly 1 IDLE cycle.
REQ-022 In IDLE and GAP, tsv_dat_OUT and tsv_frm_OUT SHALL be 0.
REQ-023 busy_OUT SHALL be 1 in SEND, PAR and GAP, and 0 in IDLE.
REQ-024 in_vld_IN and in_dat_IN changes while in_rdy_OUT=0 SHALL be ignored; a captured word SHALL NOT be corrupted mid-frame.
REQ-025 The total frame length SHALL be DW+1 cycles; the minimum handshake-to-handshake spacing SHALL be DW+2+GAP_CYC cycles.

Reset
REQ-026 While rst_IN=1 at an edge: state SHALL be IDLE, shift register 0, tsv_dat_OUT=0, tsv_frm_OUT=0, busy_OUT=0, frm_cnt_OUT=0, in_rdy_OUT=0.
REQ-027 in_rdy_OUT SHALL rise at the first edge after rst_IN deasserts.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no parity cycle and no count increment; the lane SHALL be 0 from the next edge.
REQ-029 rst_IN SHALL take priority over a simultaneous handshake; the word is dropped.

Verification
REQ-030 The bench SHALL cover: DW=8, GAP_CYC=1, send 0xA5 -> tsv_dat_OUT 1,0,1,0,0,1,0,1, parity 0; tsv_frm_OUT high on cycle 1 only; frm_cnt_OUT=1; in_rdy_OUT returns 11 cycles after the handshake.
REQ-031 The bench SHALL cover: send 0x07 -> bits 1,1,1,0,0,0,0,0, parity 1.
REQ-032 The bench SHALL cover: in_vld_IN held high with words 0x01 then 0xFF and GAP_CYC=0 -> two frames separated by 1 idle cycle; second parity 0; frm_cnt_OUT=2.
REQ-033 The bench SHALL cover: rst_IN pulsed at payload bit 4 of 0xFF -> lane 0 next cycle; frm_cnt_OUT=0; in_rdy_OUT=1 one cycle after release.
REQ-034 The bench SHALL cover: 300 back-to-back frames -> frm_cnt_OUT stops at 255.
REQ-035 The bench SHALL cover: in_dat_IN toggled randomly during SEND -> serialized bits equal the captured word.
